// File: rtl/cofi_pkg.sv
// cofi_pkg: shared mode and lock-state encodings for the cofi controller.
package cofi_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, AUTO = 2'b10, RSVD = 2'b11} cofi_mode_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} cofi_state_t;
endpackage

// File: rtl/cofi_raster_meas.sv
// cofi_raster_meas: measures active width/height per frame and flags inconsistent frames.
module cofi_raster_meas #(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic              hblank,
  input  logic              vblank,
  output logic              frame_end,
  output logic              frame_valid,
  output logic [HCNT_W-1:0] frame_h,
  output logic [VCNT_W-1:0] frame_v
);
  logic              hblank_q, vblank_q, bad, bad_nxt;
  logic              pix_inc, pix_sat, line_end, line_sat, w_mis;
  logic [HCNT_W-1:0] pix_cnt, ref_w;
  logic [VCNT_W-1:0] line_cnt;
  // frame_h/frame_v already include a line end landing on the vblank-rise cycle
  always_comb begin
    pix_inc     = pix_ce && !hblank && !vblank;
    pix_sat     = pix_inc && &pix_cnt;
    line_end    = pix_ce && hblank && !hblank_q && !vblank_q && |pix_cnt;
    line_sat    = line_end && &line_cnt;
    w_mis       = line_end && |line_cnt && pix_cnt != ref_w;
    frame_v     = (line_end && !line_sat) ? line_cnt + 1'b1 : line_cnt;
    frame_h     = (line_end && line_cnt == '0) ? pix_cnt : ref_w;
    bad_nxt     = bad || pix_sat || line_sat || w_mis;
    frame_end   = pix_ce && vblank && !vblank_q;
    frame_valid = |frame_v && !bad_nxt;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      ref_w    <= '0;
      bad      <= 1'b0;
    end else if (pix_ce) begin
      hblank_q <= hblank;
      vblank_q <= vblank;
      pix_cnt  <= (frame_end || line_end) ? '0 : (pix_inc && !pix_sat) ? pix_cnt + 1'b1 : pix_cnt;
      line_cnt <= frame_end ? '0 : frame_v;
      ref_w    <= frame_end ? '0 : frame_h;
      bad      <= !frame_end && bad_nxt;
    end
endmodule

// File: rtl/cofi_ctrl.sv
// cofi_ctrl: raster lock detection and frame-synchronous blend enable.
module cofi_ctrl
  import cofi_pkg::*;
#(
  parameter int HCNT_W      = 12,
  parameter int VCNT_W      = 10,
  parameter int LOCK_FRAMES = 4,
  parameter int AUTO_HMAX   = 320
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [1:0]        mode,
  output logic              cofi_enable,
  output logic              locked,
  output logic [HCNT_W-1:0] h_active,
  output logic [VCNT_W-1:0] v_active,
  output logic              frame_pulse
);
  localparam int SW = $clog2(LOCK_FRAMES);
  localparam logic [SW-1:0] SMAX = SW'(LOCK_FRAMES - 1);
  localparam logic [HCNT_W-1:0] HMAX = HCNT_W'(AUTO_HMAX);
  logic              frame_end, frame_valid, match, target;
  logic [HCNT_W-1:0] frame_h, h_nxt;
  logic [VCNT_W-1:0] frame_v, v_nxt;
  logic [SW-1:0]     stable_cnt, stable_nxt;
  cofi_state_t       state, state_nxt;
  cofi_mode_t        mode_e;
  cofi_raster_meas #(.HCNT_W(HCNT_W), .VCNT_W(VCNT_W)) u_meas (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .hblank     (hblank),
    .vblank     (vblank),
    .frame_end  (frame_end),
    .frame_valid(frame_valid),
    .frame_h    (frame_h),
    .frame_v    (frame_v)
  );
  // target is judged on the lock state and width this frame end is about to commit
  always_comb begin
    mode_e     = cofi_mode_t'(mode);
    match      = frame_valid && frame_h == h_active && frame_v == v_active;
    stable_nxt = !match ? '0 : (stable_cnt == SMAX) ? stable_cnt : stable_cnt + 1'b1;
    state_nxt  = !frame_end ? state : (match && stable_nxt == SMAX) ? LOCKED : UNLOCKED;
    h_nxt      = (frame_valid && !match) ? frame_h : h_active;
    v_nxt      = (frame_valid && !match) ? frame_v : v_active;
    target     = mode_e == ON || (mode_e == AUTO && state_nxt == LOCKED && h_nxt <= HMAX);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= UNLOCKED;
    else          state <= state_nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stable_cnt  <= '0;
      h_active    <= '0;
      v_active    <= '0;
      cofi_enable <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= frame_end;
      if (frame_end) begin
        stable_cnt  <= stable_nxt;
        h_active    <= h_nxt;
        v_active    <= v_nxt;
        cofi_enable <= target;
      end
    end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_cofi_ctrl.sv
// tb_cofi_ctrl: directed and randomized raster stimulus against a frame-level reference model.
module tb_cofi_ctrl;
  localparam int L = 4;
  localparam int HMAX = 320;
  logic        clk = 1'b0, reset_n = 1'b1, pix_ce = 1'b0, hblank = 1'b1, vblank = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        cofi_enable, locked, frame_pulse;
  logic [11:0] h_active;
  logic [9:0]  v_active;
  int errors = 0, checks = 0;
  int mh = 0, mv = 0, run = 0;
  bit mlock = 0, men = 0;

  cofi_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .hblank     (hblank),
    .vblank     (vblank),
    .mode       (mode),
    .cofi_enable(cofi_enable),
    .locked     (locked),
    .h_active   (h_active),
    .v_active   (v_active),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(mlock));
    chk({tag, ".enable"}, 32'(cofi_enable), 32'(men));
    chk({tag, ".h_active"}, 32'(h_active), 32'(mh));
    chk({tag, ".v_active"}, 32'(v_active), 32'(mv));
  endtask

  task automatic cyc(input bit ce, input bit hb, input bit vb);
    @(negedge clk);
    pix_ce = ce;
    hblank = hb;
    vblank = vb;
  endtask

  // one pixel-enabled sample, sometimes preceded by a gated cycle with junk blanks
  task automatic px(input bit hb, input bit vb);
    if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc(1'b1, hb, vb);
  endtask

  // a run of identical valid frames is what lock means; anything else restarts it
  task automatic model_frame(input bit valid, input int h, input int v);
    bit same;
    same = valid && h == mh && v == mv;
    if (same) run = (run < L - 1) ? run + 1 : run;
    else begin
      run = 0;
      if (valid) begin mh = h; mv = v; end
    end
    mlock = same && run == L - 1;
    men = (mode == 2'd1) || (mode == 2'd2 && mlock && mh <= HMAX);
  endtask

  task automatic frame(input string tag, input int w, input int nl, input int bl, input int bw, input int mchg);
    int w0, lw;
    bit same;
    w0 = 0;
    same = 1;
    for (int l = 0; l < nl; l++) begin
      lw = (l == bl) ? bw : w;
      if (l == 0) w0 = lw;
      else if (lw != w0) same = 0;
      for (int p = 0; p < lw; p++) px(1'b0, 1'b0);
      if (l == nl - 1 && $urandom_range(0, 1) == 1) px(1'b1, 1'b1);
      else begin
        for (int k = 0; k < 3; k++) px(1'b1, 1'b0);
        if (l == nl / 2 && mchg >= 0) begin
          mode = 2'(mchg);
          cyc(1'b0, 1'b1, 1'b0);
          cyc(1'b0, 1'b1, 1'b0);
          chk({tag, ".deferred_enable"}, 32'(cofi_enable), 32'(men));
        end
        if (l == nl - 1) px(1'b1, 1'b1);
      end
    end
    model_frame(same, w0, nl);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(frame_pulse), 32'd1);
    check_all(tag);
    @(negedge clk);
    chk({tag, ".pulse_fall"}, 32'(frame_pulse), 32'd0);
    px(1'b1, 1'b1);
    px(1'b1, 1'b1);
    px(1'b1, 1'b0);
  endtask

  initial begin
    int w, h, bl, bw;
    logic [11:0] h0;
    logic [9:0]  v0;
    logic        l0, e0;
    #2 reset_n = 1'b0;
    #1;
    chk("por.pulse", 32'(frame_pulse), 32'd0);
    check_all("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    mode = 2'd2;
    for (int i = 0; i < 5; i++) frame("auto256", 256, 4, -1, 0, -1);
    for (int i = 0; i < 4; i++) frame("auto321", 321, 3, -1, 0, -1);
    for (int i = 0; i < 4; i++) frame("auto320", 320, 2, -1, 0, -1);

    mode = 2'd0;
    for (int i = 0; i < 4; i++) frame("off", 24, 6, -1, 0, -1);
    frame("off_to_on", 24, 6, -1, 0, 1);

    mode = 2'd2;
    frame("auto24", 24, 6, -1, 0, -1);
    frame("short_line", 24, 6, 3, 23, -1);
    for (int i = 0; i < 4; i++) frame("relock", 24, 6, -1, 0, -1);

    h0 = h_active; v0 = v_active; l0 = locked; e0 = cofi_enable;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("gated.pulse", 32'(frame_pulse), 32'd0);
    end
    chk("gated.h_active", 32'(h_active), 32'(h0));
    chk("gated.v_active", 32'(v_active), 32'(v0));
    chk("gated.locked", 32'(locked), 32'(l0));
    chk("gated.enable", 32'(cofi_enable), 32'(e0));
    cyc(1'b0, 1'b1, 1'b0);

    w = 20; h = 3;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(8, 40);
        h = $urandom_range(1, 5);
      end
      mode = 2'($urandom_range(0, 3));
      bl = -1; bw = 0;
      if ($urandom_range(0, 5) == 0) begin
        bl = $urandom_range(0, h - 1);
        bw = w + $urandom_range(1, 3);
      end
      frame("rand", w, h, bl, bw, -1);
    end

    mode = 2'd1;
    for (int i = 0; i < 4; i++) frame("prereset", 20, 3, -1, 0, -1);
    for (int p = 0; p < 5; p++) px(1'b0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    mh = 0; mv = 0; run = 0; mlock = 0; men = 0;
    chk("async_rst.pulse", 32'(frame_pulse), 32'd0);
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    mode = 2'd2;
    frame("partial", 20, 3, 0, 10, -1);
    for (int i = 0; i < 4; i++) frame("post_rst", 20, 3, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
